// File: rtl/riscv_zero_fetch_buf.sv
// Fetch stage: issues in-order imem requests, buffers {pc, inst} for decode.
// Latency: response accepted in cycle N is visible on d_valid in cycle N+1.
// Backpressure: requests need a free slot counting in-flight plus buffered entries.
module riscv_zero_fetch_buf #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_pc,
  output logic [31:0] d_inst
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   buf_inst [DEPTH];

  logic [CW:0]   credit_used;
  logic [31:0]   target_pc;
  logic          req_fire;
  logic          rsp_stale;
  logic          push;
  logic          pop;
  logic          unused_redirect_lsbs;

  // Low address bits of a redirect are meaningless for word-aligned fetch.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Credit uses registered state only, so a slot freed this cycle is reused next cycle.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses for requests issued before a redirect are discarded.
  assign rsp_stale = (drop_cnt != '0);
  assign push      = imem_rsp_valid && !rsp_stale && !redirect_valid;

  assign d_valid = (count != '0);
  assign pop     = d_valid && d_ready && !redirect_valid;
  assign d_pc    = d_valid ? buf_pc[rd_ptr]   : 32'h0;
  assign d_inst  = d_valid ? buf_inst[rd_ptr] : 32'h0;

  // Request side: next fetch address and number of unanswered requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= target_pc;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  // Response side: PC tagging for live responses, drop counting for stale ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_pc   <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight is stale; a response arriving now is dropped too.
      rsp_pc   <= target_pc;
      drop_cnt <= outstanding - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid) begin
      if (rsp_stale) begin
        drop_cnt <= drop_cnt - CW'(1);
      end else begin
        rsp_pc <= rsp_pc + 32'd4;
      end
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; contents are only observed through count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= rsp_pc;
      buf_inst[wr_ptr] <= imem_rsp_data;
    end
  end

  // Credit accounting guarantees a live response always finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push && !pop) |-> ({1'b0, count} < LIMIT));

  // Memory must never answer more requests than were accepted.
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding != '0));

endmodule
